// File: rtl/fsm_multi_seq_pkg.sv
// Shared types and helpers for the multi-channel qualification FSM.
// State encoding is fixed so traces stay readable across versions.
package fsm_multi_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STATE_1 = 2'd1,
    FINAL   = 2'd2,
    COOL    = 2'd3
  } state_t;

  function automatic int seq_w(input int arm, input int cool);
    int m;
    int w;
    m = (arm > cool) ? arm : cool;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fsm_multi_seq_if.sv
// Channel bundle between a level-input driver and the qualifier.
// Master drives inputs and clear, slave returns decoded state.
interface fsm_multi_seq_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
);
  logic                   clr;
  logic [NCH-1:0]         a;
  logic [NCH-1:0]         out1;
  logic [NCH-1:0]         out2;
  logic [NCH-1:0]         busy;
  logic                   any_final;
  logic [NCH*CNT_W-1:0]   hit_cnt;

  modport master (
    output clr,
    output a,
    input  out1,
    input  out2,
    input  busy,
    input  any_final,
    input  hit_cnt
  );

  modport slave (
    input  clr,
    input  a,
    output out1,
    output out2,
    output busy,
    output any_final,
    output hit_cnt
  );
endinterface

// File: rtl/fsm_seq_chan.sv
// One qualification channel: Moore FSM, shared arm/cool counter,
// saturating hit counter with synchronous clear.
module fsm_seq_chan
  import fsm_multi_seq_pkg::*;
#(
  parameter int ARM_CYCLES  = 1,
  parameter int COOL_CYCLES = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             a,
  output logic             out1,
  output logic             out2,
  output logic             busy,
  output logic [CNT_W-1:0] hit
);

  localparam int SW = seq_w(ARM_CYCLES, COOL_CYCLES);
  localparam logic [SW-1:0] ARM_N  = SW'(ARM_CYCLES);
  localparam logic [SW-1:0] COOL_N = SW'(COOL_CYCLES);
  localparam logic [SW-1:0] ONE    = SW'(1);

  state_t           st_q;
  state_t           st_d;
  logic [SW-1:0]    sc_q;
  logic [SW-1:0]    sc_d;
  logic [CNT_W-1:0] hit_q;
  logic [CNT_W-1:0] hit_d;
  logic             inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= IDLE;
      sc_q  <= '0;
      hit_q <= '0;
    end else begin
      st_q  <= st_d;
      sc_q  <= sc_d;
      hit_q <= hit_d;
    end
  end

  always_comb begin
    st_d = st_q;
    sc_d = sc_q;
    inc  = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (a) begin
          st_d = STATE_1;
          sc_d = ONE;
        end
      end
      STATE_1: begin
        if (!a) begin
          st_d = IDLE;
          sc_d = '0;
        end else if (sc_q == ARM_N) begin
          st_d = FINAL;
          inc  = 1'b1;
        end else begin
          sc_d = sc_q + ONE;
        end
      end
      FINAL: begin
        if (!a) begin
          if (COOL_CYCLES > 0) begin
            st_d = COOL;
            sc_d = ONE;
          end else begin
            st_d = IDLE;
          end
        end
      end
      COOL: begin
        if (sc_q == COOL_N) begin
          st_d = IDLE;
        end else begin
          sc_d = sc_q + ONE;
        end
      end
      default: begin
        st_d = IDLE;
        sc_d = '0;
      end
    endcase
  end

  // clear wins over the old count but never swallows a same-cycle hit
  always_comb begin
    hit_d = hit_q;
    if (clr) begin
      hit_d = CNT_W'(inc);
    end else if (inc && (hit_q != {CNT_W{1'b1}})) begin
      hit_d = hit_q + CNT_W'(1);
    end
  end

  assign out1 = (st_q == STATE_1);
  assign out2 = (st_q == FINAL);
  assign busy = (st_q == COOL);
  assign hit  = hit_q;

endmodule

// File: rtl/fsm_multi_seq.sv
// NCH independent qualification channels with packed hit counters
// and a combined FINAL indicator.
module fsm_multi_seq
  import fsm_multi_seq_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int ARM_CYCLES  = 1,
  parameter int COOL_CYCLES = 0,
  parameter int CNT_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  fsm_multi_seq_if.slave  bus
);

  logic [NCH-1:0]       o1;
  logic [NCH-1:0]       o2;
  logic [NCH-1:0]       bz;
  logic [NCH*CNT_W-1:0] hc;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    fsm_seq_chan #(
      .ARM_CYCLES  (ARM_CYCLES),
      .COOL_CYCLES (COOL_CYCLES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .clr  (bus.clr),
      .a    (bus.a[i]),
      .out1 (o1[i]),
      .out2 (o2[i]),
      .busy (bz[i]),
      .hit  (hc[i*CNT_W +: CNT_W])
    );
  end

  assign bus.out1      = o1;
  assign bus.out2      = o2;
  assign bus.busy      = bz;
  assign bus.hit_cnt   = hc;
  assign bus.any_final = |o2;

endmodule

// File: tb/tb_fsm_multi_seq.sv
// Scoreboard bench: three configurations driven in lockstep against
// a behavioural channel model, plus directed checks.
module tb_fsm_multi_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fsm_multi_seq_if #(.NCH(4), .CNT_W(2)) if0 ();
  fsm_multi_seq_if #(.NCH(1), .CNT_W(8)) if1 ();
  fsm_multi_seq_if #(.NCH(1), .CNT_W(8)) if2 ();

  fsm_multi_seq #(
    .NCH(4), .ARM_CYCLES(1), .COOL_CYCLES(0), .CNT_W(2)
  ) d0 (.clk(clk), .rst(rst), .bus(if0));

  fsm_multi_seq #(
    .NCH(1), .ARM_CYCLES(3), .COOL_CYCLES(0), .CNT_W(8)
  ) d1 (.clk(clk), .rst(rst), .bus(if1));

  fsm_multi_seq #(
    .NCH(1), .ARM_CYCLES(1), .COOL_CYCLES(2), .CNT_W(8)
  ) d2 (.clk(clk), .rst(rst), .bus(if2));

  int p_nc[3]   = '{4, 1, 1};
  int p_arm[3]  = '{1, 3, 1};
  int p_cool[3] = '{0, 0, 2};
  int p_cw[3]   = '{2, 8, 8};

  int st[3][4];
  int sc[3][4];
  int hc[3][4];

  typedef struct packed {
    logic [2:0][3:0]  o1;
    logic [2:0][3:0]  o2;
    logic [2:0][3:0]  bz;
    logic [2:0]       af;
    logic [2:0][15:0] hit;
  } exp_t;

  exp_t sbq[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 4; c++) begin
        st[k][c] = 0;
        sc[k][c] = 0;
        hc[k][c] = 0;
      end
  endtask

  task automatic mstep(input logic [2:0][3:0] av, input logic c);
    for (int k = 0; k < 3; k++) begin
      for (int ch = 0; ch < p_nc[k]; ch++) begin
        int  mx;
        bit  inc;
        logic x;
        mx  = (1 << p_cw[k]) - 1;
        inc = 0;
        x   = av[k][ch];
        case (st[k][ch])
          0: if (x) begin st[k][ch] = 1; sc[k][ch] = 1; end
          1: begin
            if (!x) st[k][ch] = 0;
            else if (sc[k][ch] == p_arm[k]) begin
              st[k][ch] = 2;
              inc = 1;
            end else sc[k][ch]++;
          end
          2: if (!x) begin
            if (p_cool[k] > 0) begin
              st[k][ch] = 3;
              sc[k][ch] = 1;
            end else st[k][ch] = 0;
          end
          default: begin
            if (sc[k][ch] == p_cool[k]) st[k][ch] = 0;
            else sc[k][ch]++;
          end
        endcase
        if (c) hc[k][ch] = inc ? 1 : 0;
        else if (inc && hc[k][ch] < mx) hc[k][ch]++;
      end
    end
  endtask

  function automatic exp_t mexp();
    exp_t e;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      for (int ch = 0; ch < p_nc[k]; ch++) begin
        e.o1[k][ch] = (st[k][ch] == 1);
        e.o2[k][ch] = (st[k][ch] == 2);
        e.bz[k][ch] = (st[k][ch] == 3);
        e.hit[k] = e.hit[k] | 16'(hc[k][ch] << (ch * p_cw[k]));
      end
      e.af[k] = |e.o2[k];
    end
    return e;
  endfunction

  task automatic cyc(input logic [3:0] a0, input logic a1,
                     input logic a2, input logic c);
    logic [2:0][3:0]  av;
    logic [2:0][3:0]  g1, g2, gb;
    logic [2:0]       gf;
    logic [2:0][15:0] gh;
    exp_t e;
    if0.a = a0;
    if1.a = a1;
    if2.a = a2;
    if0.clr = c;
    if1.clr = c;
    if2.clr = c;
    av = {{3'b0, a2}, {3'b0, a1}, a0};
    mstep(av, c);
    sbq.push_back(mexp());
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_underflow", 0, 1);
    end else begin
      e  = sbq.pop_front();
      g1 = {{3'b0, if2.out1}, {3'b0, if1.out1}, if0.out1};
      g2 = {{3'b0, if2.out2}, {3'b0, if1.out2}, if0.out2};
      gb = {{3'b0, if2.busy}, {3'b0, if1.busy}, if0.busy};
      gf = {if2.any_final, if1.any_final, if0.any_final};
      gh = {{8'b0, if2.hit_cnt}, {8'b0, if1.hit_cnt},
            {8'b0, if0.hit_cnt}};
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("sb_out1[%0d]", k), 64'(g1[k]), 64'(e.o1[k]));
        chk($sformatf("sb_out2[%0d]", k), 64'(g2[k]), 64'(e.o2[k]));
        chk($sformatf("sb_busy[%0d]", k), 64'(gb[k]), 64'(e.bz[k]));
        chk($sformatf("sb_anyf[%0d]", k), 64'(gf[k]), 64'(e.af[k]));
        chk($sformatf("sb_hit[%0d]", k), 64'(gh[k]), 64'(e.hit[k]));
      end
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_out1"}, 64'({if2.out1, if1.out1, if0.out1}), 0);
    chk({tag, "_out2"}, 64'({if2.out2, if1.out2, if0.out2}), 0);
    chk({tag, "_busy"}, 64'({if2.busy, if1.busy, if0.busy}), 0);
    chk({tag, "_anyf"},
        64'({if2.any_final, if1.any_final, if0.any_final}), 0);
    chk({tag, "_hit0"}, 64'(if0.hit_cnt), 0);
    chk({tag, "_hit12"}, 64'({if2.hit_cnt, if1.hit_cnt}), 0);
  endtask

  task automatic pulse_rst(input string tag);
    #2 rst = 1'b1;
    #1 all_zero(tag);
    mreset();
    #1 rst = 1'b0;
  endtask

  logic [0:9] l_a0  = 10'b0111000000;
  logic [0:9] l_o1  = 10'b0100000000;
  logic [0:9] l_o2  = 10'b0011000000;
  logic [0:9] b_a   = 10'b1110111100;
  logic [0:9] b_o2  = 10'b0000000100;
  logic [0:9] c_a   = 10'b1101111000;
  logic [0:9] c_bz  = 10'b0011000110;
  logic [0:9] c_o1  = 10'b1000010000;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    if0.a = '0; if1.a = '0; if2.a = '0;
    if0.clr = 1'b0; if1.clr = 1'b0; if2.clr = 1'b0;
    mreset();
    #12;
    all_zero("reset");
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cyc({3'b0, l_a0[i]}, b_a[i], c_a[i], 1'b0);
      chk($sformatf("legacy_out1_%0d", i), 64'(if0.out1[0]), 64'(l_o1[i]));
      chk($sformatf("legacy_out2_%0d", i), 64'(if0.out2[0]), 64'(l_o2[i]));
      chk($sformatf("abort_out2_%0d", i), 64'(if1.out2), 64'(b_o2[i]));
      chk($sformatf("cool_busy_%0d", i), 64'(if2.busy), 64'(c_bz[i]));
      chk($sformatf("cool_out1_%0d", i), 64'(if2.out1), 64'(c_o1[i]));
    end
    chk("legacy_hit", 64'(if0.hit_cnt[1:0]), 1);
    chk("abort_hit", 64'(if1.hit_cnt), 1);
    chk("cool_hit", 64'(if2.hit_cnt), 2);

    for (int i = 0; i < 5; i++) begin
      cyc(4'b0001, 0, 0, 0);
      cyc(4'b0001, 0, 0, 0);
      cyc(4'b0000, 0, 0, 0);
    end
    chk("sat_hit", 64'(if0.hit_cnt[1:0]), 3);
    cyc(4'b0001, 0, 0, 0);
    cyc(4'b0001, 0, 0, 1);
    chk("clr_inc_hit", 64'(if0.hit_cnt[1:0]), 1);
    chk("clr_inc_all", 64'({if2.hit_cnt, if1.hit_cnt}), 0);
    cyc(4'b0000, 0, 0, 1);
    chk("clr_only_hit", 64'(if0.hit_cnt), 0);

    cyc(4'b0101, 0, 0, 0);
    cyc(4'b0101, 0, 0, 0);
    chk("indep_out2", 64'(if0.out2), 64'h5);
    chk("indep_anyf", 64'(if0.any_final), 1);
    cyc(4'b0000, 0, 0, 0);
    chk("indep_out2_off", 64'(if0.out2), 0);
    chk("indep_anyf_off", 64'(if0.any_final), 0);

    cyc(4'b1111, 1, 1, 0);
    pulse_rst("rst_s1");
    cyc(4'b1111, 1, 1, 0);
    chk("rel_out1", 64'(if0.out1), 64'hf);
    cyc(4'b1111, 1, 1, 0);
    chk("pre_rst_out2", 64'(if0.out2), 64'hf);
    pulse_rst("rst_final");
    cyc(4'b0000, 0, 0, 0);
    chk("post_rst_hit", 64'(if0.hit_cnt), 0);

    for (int i = 0; i < 300; i++) begin
      cyc(4'($urandom_range(0, 15)),
          $urandom_range(0, 4) != 0,
          $urandom_range(0, 1) != 0,
          $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
